// File: rtl/seq_logic_unit.sv
`default_nettype none
// ============================================================================
// seq_logic_unit : bitwise AND/OR/XOR/NOR computed one SLICE per clock
// Revision       : 1.0
// ============================================================================
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic [WIDTH-1:0] w_full;
  logic [WIDTH-1:0] w_next_result;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);

  always_comb begin
    w_full = r_a & r_b;
    case (r_op)
      2'b00:   w_full = r_a & r_b;
      2'b01:   w_full = r_a | r_b;
      2'b10:   w_full = r_a ^ r_b;
      default: w_full = ~(r_a | r_b);
    endcase
  end

  // Only the slice selected by the counter takes the new value; the rest hold.
  for (genvar i = 0; i < N; i++) begin : g_slice
    assign w_next_result[i*SLICE +: SLICE] = (r_cnt == CW'(i)) ?
        w_full[i*SLICE +: SLICE] : r_result[i*SLICE +: SLICE];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = RUN;
      end
      RUN:  if (w_last) w_next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= input_a;
      r_b      <= input_b;
      r_op     <= op;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (r_state == RUN) begin
      r_result <= w_next_result;
      if (w_last) begin
        r_zero <= (w_next_result == '0);
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign result      = r_result;
  assign result_zero = r_zero;

endmodule
`default_nettype wire

// File: doc/seq_logic_unit.md
SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SLICE, default 8: bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous abort of any operation in flight.
REQ-006 in_valid  input  1  operands and op presented.
REQ-007 in_ready  output  1  unit can accept operands.
REQ-008 input_a  input  WIDTH  first operand.
REQ-009 input_b  input  WIDTH  second operand.
REQ-010 op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  bitwise result of captured operands under captured op.
REQ-014 result_zero  output  1  high when result equals 0; qualified by out_valid.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; in_ready = 1 exactly in IDLE; out_valid = 1 exactly in DONE.
REQ-016 Accept = in_valid && in_ready at a rising edge: capture input_a, input_b, op; clear result to 0; clear slice counter to 0; go to RUN.
REQ-017 Each RUN edge SHALL write slice k of result (bits k*SLICE .. k*SLICE+SLICE-1) from captured operands/op, then increment k.
REQ-018 The edge writing slice N-1 SHALL also load result_zero and move to DONE; out_valid rises exactly N edges after the accept edge (N=4 at defaults; N=1 when SLICE=WIDTH).
REQ-019 Operand/op inputs changing after accept SHALL NOT affect the operation in flight.
REQ-020 DONE: result and result_zero held stable until out_valid && out_ready at an edge, then go to IDLE; no same-edge re-accept (in_ready rises the cycle after the output handshake).
REQ-021 in_valid while not in IDLE SHALL be ignored.
REQ-022 flush high at an edge SHALL force IDLE, out_valid 0, counter 0, result 0, result_zero 0, in any state.
REQ-023 flush and in_valid together in IDLE: flush wins, no accept.
REQ-024 Slice counter SHALL be ceil(log2(N)) bits (min 1) and never exceed N-1.

Reset
REQ-025 rst_n low SHALL immediately (without clk) force IDLE, counter 0, result 0, result_zero 0, out_valid 0; in_ready reads 1 during and after reset.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no out_valid until a new accept completes.

Verification (WIDTH=32, SLICE=8 unless noted)
REQ-027 OR: a=0xF0F00000, b=0x0F0F00FF, op=01, out_ready=1 -> out_valid 4 cycles after accept, result=0xFFFF00FF, result_zero=0.
REQ-028 NOR: a=0xFFFFFFFF, b=0x00000000, op=11 -> result=0x00000000, result_zero=1; XOR a=b=0x12345678 -> result 0, result_zero=1.
REQ-029 Backpressure: out_ready=0 for 10 cycles after DONE, in_valid=1 throughout -> result stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge, in_ready=1, new accept one edge later.
REQ-030 flush asserted when counter=2 in RUN -> next edge IDLE, out_valid never rises, result=0; flush+in_valid in IDLE -> no accept.
REQ-031 rst_n pulsed low mid-RUN between edges -> outputs zero immediately, in_ready=1; subsequent AND a=0xFF00FF00, b=0x0FF00FF0 -> result 0x0F000F00.
REQ-032 Parameter sweep WIDTH=16, SLICE=16: AND a=0xAAAA, b=0xFFFF -> out_valid 1 edge after accept, result=0xAAAA; WIDTH=64, SLICE=4: latency 16 edges.
